// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Package  : control_pkg
// Brief    : Opcode codes, ALU-op encoding and per-stage control bundles.
// Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

  localparam int c_reg_addr_w = 5;

  // opcode[6:2] major codes; opcode[1:0] must equal c_opc_low
  localparam logic [1:0] c_opc_low    = 2'b11;
  localparam logic [4:0] c_opc_load   = 5'b00000;
  localparam logic [4:0] c_opc_op_imm = 5'b00100;
  localparam logic [4:0] c_opc_auipc  = 5'b00101;
  localparam logic [4:0] c_opc_store  = 5'b01000;
  localparam logic [4:0] c_opc_op     = 5'b01100;
  localparam logic [4:0] c_opc_lui    = 5'b01101;
  localparam logic [4:0] c_opc_branch = 5'b11000;
  localparam logic [4:0] c_opc_jalr   = 5'b11001;
  localparam logic [4:0] c_opc_jal    = 5'b11011;

  typedef enum logic [1:0] {
    ALUOP_FUNCT = 2'b00,
    ALUOP_ADDR  = 2'b10,
    ALUOP_LUI   = 2'b11
  } aluop_t;

  typedef struct packed {
    aluop_t aluop;
    logic   alusrc;
    logic   branch;
    logic   pcread;
  } ex_ctrl_t;

  typedef struct packed {
    logic memwrite;
    logic memread;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic addpc;
  } wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Brief    : Combinational opcode to {ex, mem, wb} control bundle decoder.
// Revision : 1.0 - initial release
// ============================================================================
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output ex_ctrl_t   ex_ctrl,
  output mem_ctrl_t  mem_ctrl,
  output wb_ctrl_t   wb_ctrl,
  output logic       illegal,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    ex_ctrl  = '0;
    mem_ctrl = '0;
    wb_ctrl  = '0;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    if (opcode[1:0] != c_opc_low) begin
      illegal = 1'b1;
    end else begin
      case (opcode[6:2])
        c_opc_load: begin
          ex_ctrl.aluop    = ALUOP_ADDR;
          ex_ctrl.alusrc   = 1'b1;
          mem_ctrl.memread = 1'b1;
          wb_ctrl.memtoreg = 1'b1;
          wb_ctrl.regwrite = 1'b1;
          rs1_used         = 1'b1;
        end
        c_opc_op_imm: begin
          ex_ctrl.aluop    = ALUOP_FUNCT;
          ex_ctrl.alusrc   = 1'b1;
          wb_ctrl.regwrite = 1'b1;
          rs1_used         = 1'b1;
        end
        c_opc_store: begin
          ex_ctrl.aluop     = ALUOP_ADDR;
          ex_ctrl.alusrc    = 1'b1;
          mem_ctrl.memwrite = 1'b1;
          rs1_used          = 1'b1;
          rs2_used          = 1'b1;
        end
        c_opc_op: begin
          ex_ctrl.aluop    = ALUOP_FUNCT;
          wb_ctrl.regwrite = 1'b1;
          rs1_used         = 1'b1;
          rs2_used         = 1'b1;
        end
        c_opc_branch: begin
          ex_ctrl.aluop  = ALUOP_FUNCT;
          ex_ctrl.branch = 1'b1;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end
        c_opc_jalr: begin
          ex_ctrl.aluop    = ALUOP_ADDR;
          ex_ctrl.pcread   = 1'b1;
          wb_ctrl.regwrite = 1'b1;
          wb_ctrl.addpc    = 1'b1;
          rs1_used         = 1'b1;
        end
        c_opc_jal: begin
          ex_ctrl.aluop    = ALUOP_ADDR;
          ex_ctrl.pcread   = 1'b1;
          ex_ctrl.alusrc   = 1'b1;
          wb_ctrl.regwrite = 1'b1;
          wb_ctrl.addpc    = 1'b1;
        end
        c_opc_lui: begin
          ex_ctrl.aluop    = ALUOP_LUI;
          ex_ctrl.alusrc   = 1'b1;
          wb_ctrl.regwrite = 1'b1;
        end
        c_opc_auipc: begin
          ex_ctrl.aluop    = ALUOP_FUNCT;
          ex_ctrl.pcread   = 1'b1;
          ex_ctrl.alusrc   = 1'b1;
          wb_ctrl.regwrite = 1'b1;
          wb_ctrl.addpc    = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Brief    : ID decode plus EX/MEM/WB control registers with load-use,
//            stall and flush handling.
// Revision : 1.0 - initial release
// ============================================================================
module control_pipe
  import control_pkg::*;
#(
  parameter int REG_ADDR_W   = c_reg_addr_w,
  parameter bit HAZARD_EN    = 1'b1,
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [6:0]            id_opcode_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  id_illegal_o,
  output logic                  hazard_stall_o,
  output logic                  ex_valid_o,
  output logic [1:0]            ex_aluop_o,
  output logic                  ex_alusrc_o,
  output logic                  ex_branch_o,
  output logic                  ex_pcread_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  mem_valid_o,
  output logic                  mem_memwrite_o,
  output logic                  mem_memread_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic                  wb_valid_o,
  output logic                  wb_memtoreg_o,
  output logic                  wb_regwrite_o,
  output logic                  wb_addpc_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o
);

  ex_ctrl_t  w_dec_ex;
  mem_ctrl_t w_dec_mem;
  wb_ctrl_t  w_dec_wb;
  wb_ctrl_t  w_id_wb;
  logic      w_dec_illegal;
  logic      w_rs1_used;
  logic      w_rs2_used;
  logic      w_hazard;
  logic      w_accept;

  logic                  r_ex_valid;
  ex_ctrl_t              r_ex_ctrl;
  mem_ctrl_t             r_ex_mem;
  wb_ctrl_t              r_ex_wb;
  logic [REG_ADDR_W-1:0] r_ex_rd;

  logic                  r_mem_valid;
  mem_ctrl_t             r_mem_ctrl;
  wb_ctrl_t              r_mem_wb;
  logic [REG_ADDR_W-1:0] r_mem_rd;

  logic                  r_wb_valid;
  wb_ctrl_t              r_wb_ctrl;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  control_decode u_decode (
    .opcode   (id_opcode_i),
    .ex_ctrl  (w_dec_ex),
    .mem_ctrl (w_dec_mem),
    .wb_ctrl  (w_dec_wb),
    .illegal  (w_dec_illegal),
    .rs1_used (w_rs1_used),
    .rs2_used (w_rs2_used)
  );

  // Writes to x0 are architecturally discarded; drop them at the source
  always_comb begin
    w_id_wb = w_dec_wb;
    if (RD0_SUPPRESS && (id_rd_i == '0)) begin
      w_id_wb.regwrite = 1'b0;
    end
  end

  generate
    if (HAZARD_EN) begin : g_hazard
      logic w_rs1_hit;
      logic w_rs2_hit;
      assign w_rs1_hit = w_rs1_used && (r_ex_rd == id_rs1_i);
      assign w_rs2_hit = w_rs2_used && (r_ex_rd == id_rs2_i);
      assign w_hazard  = id_valid_i && r_ex_valid && r_ex_mem.memread &&
                         (r_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
    end else begin : g_no_hazard
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign w_accept       = id_valid_i && !w_dec_illegal && !flush_i && !w_hazard;
  assign id_illegal_o   = id_valid_i && w_dec_illegal;
  assign hazard_stall_o = w_hazard;

  // Stall freezes everything; otherwise MEM/WB always advance and EX either
  // takes the ID instruction or a bubble (flush, hazard, illegal, empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_mem    <= '0;
      r_ex_wb     <= '0;
      r_ex_rd     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_mem_wb    <= '0;
      r_mem_rd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
    end else if (!stall_i) begin
      r_mem_valid <= r_ex_valid;
      r_mem_ctrl  <= r_ex_mem;
      r_mem_wb    <= r_ex_wb;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_ctrl   <= r_mem_wb;
      r_wb_rd     <= r_mem_rd;
      if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_ex_ctrl  <= w_dec_ex;
        r_ex_mem   <= w_dec_mem;
        r_ex_wb    <= w_id_wb;
        r_ex_rd    <= id_rd_i;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= '0;
        r_ex_mem   <= '0;
        r_ex_wb    <= '0;
        r_ex_rd    <= '0;
      end
    end
  end

  assign ex_valid_o     = r_ex_valid;
  assign ex_aluop_o     = r_ex_valid ? r_ex_ctrl.aluop : 2'b00;
  assign ex_alusrc_o    = r_ex_valid && r_ex_ctrl.alusrc;
  assign ex_branch_o    = r_ex_valid && r_ex_ctrl.branch;
  assign ex_pcread_o    = r_ex_valid && r_ex_ctrl.pcread;
  assign ex_rd_o        = {REG_ADDR_W{r_ex_valid}} & r_ex_rd;

  assign mem_valid_o    = r_mem_valid;
  assign mem_memwrite_o = r_mem_valid && r_mem_ctrl.memwrite;
  assign mem_memread_o  = r_mem_valid && r_mem_ctrl.memread;
  assign mem_rd_o       = {REG_ADDR_W{r_mem_valid}} & r_mem_rd;

  assign wb_valid_o     = r_wb_valid;
  assign wb_memtoreg_o  = r_wb_valid && r_wb_ctrl.memtoreg;
  assign wb_regwrite_o  = r_wb_valid && r_wb_ctrl.regwrite;
  assign wb_addpc_o     = r_wb_valid && r_wb_ctrl.addpc;
  assign wb_rd_o        = {REG_ADDR_W{r_wb_valid}} & r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipe
// Brief    : Scoreboard bench for control_pipe against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_pipe;

  localparam int RW = 5;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid_i = 1'b0;
  logic [6:0]    id_opcode_i = '0;
  logic [RW-1:0] id_rd_i = '0, id_rs1_i = '0, id_rs2_i = '0;
  logic          stall_i = 1'b0, flush_i = 1'b0;
  logic          id_illegal_o, hazard_stall_o;
  logic          ex_valid_o, ex_alusrc_o, ex_branch_o, ex_pcread_o;
  logic [1:0]    ex_aluop_o;
  logic [RW-1:0] ex_rd_o, mem_rd_o, wb_rd_o;
  logic          mem_valid_o, mem_memwrite_o, mem_memread_o;
  logic          wb_valid_o, wb_memtoreg_o, wb_regwrite_o, wb_addpc_o;

  control_pipe #(.REG_ADDR_W(RW), .HAZARD_EN(1'b1), .RD0_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .id_illegal_o(id_illegal_o), .hazard_stall_o(hazard_stall_o),
    .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_branch_o(ex_branch_o), .ex_pcread_o(ex_pcread_o), .ex_rd_o(ex_rd_o),
    .mem_valid_o(mem_valid_o), .mem_memwrite_o(mem_memwrite_o),
    .mem_memread_o(mem_memread_o), .mem_rd_o(mem_rd_o),
    .wb_valid_o(wb_valid_o), .wb_memtoreg_o(wb_memtoreg_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_addpc_o(wb_addpc_o), .wb_rd_o(wb_rd_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       legal;
    bit [1:0] aluop;
    bit       alusrc, branch, pcread, memwrite, memread, memtoreg, regwrite, addpc;
    bit       use1, use2;
  } dec_t;

  typedef struct packed {
    bit       valid;
    bit       memread;
    bit [1:0] aluop;
    bit       alusrc, branch, pcread;
    bit [4:0] rd;
  } ex_m_t;

  typedef struct packed {
    bit        memwrite, memread, memtoreg, regwrite, addpc;
    bit [4:0]  rd;
    bit [31:0] due;
  } ent_t;

  ex_m_t       m_ex;
  ent_t        exp_q[$];
  int unsigned adv;
  bit          last_stall, last_hz;
  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_wb;
  logic [7:0]  exp_mem;

  // The instruction table, row by row
  function automatic dec_t ref_decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_LW:    begin d.aluop = 2'b10; d.alusrc = 1; d.memtoreg = 1; d.memread = 1; d.regwrite = 1; d.use1 = 1; end
      OP_ADDI:  begin d.aluop = 2'b00; d.alusrc = 1; d.regwrite = 1; d.use1 = 1; end
      OP_SW:    begin d.aluop = 2'b10; d.alusrc = 1; d.memwrite = 1; d.use1 = 1; d.use2 = 1; end
      OP_ADD:   begin d.aluop = 2'b00; d.regwrite = 1; d.use1 = 1; d.use2 = 1; end
      OP_BEQ:   begin d.aluop = 2'b00; d.branch = 1; d.use1 = 1; d.use2 = 1; end
      OP_JALR:  begin d.aluop = 2'b10; d.pcread = 1; d.regwrite = 1; d.addpc = 1; d.use1 = 1; end
      OP_JAL:   begin d.aluop = 2'b10; d.pcread = 1; d.alusrc = 1; d.regwrite = 1; d.addpc = 1; end
      OP_LUI:   begin d.aluop = 2'b11; d.alusrc = 1; d.regwrite = 1; end
      OP_AUIPC: begin d.aluop = 2'b00; d.pcread = 1; d.alusrc = 1; d.regwrite = 1; d.addpc = 1; end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // One ID cycle: drive, check the combinational outputs, then advance the model
  task automatic step(input bit v, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit st, input bit fl);
    dec_t d;
    bit   hz;
    ent_t e;
    @(negedge clk);
    #2;
    id_valid_i = v; id_opcode_i = op; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    stall_i = st; flush_i = fl;
    #1;
    d  = ref_decode(op);
    hz = v && m_ex.valid && m_ex.memread && (m_ex.rd != 0) &&
         ((d.use1 && m_ex.rd == rs1) || (d.use2 && m_ex.rd == rs2));
    chk("hazard_stall", {31'b0, hazard_stall_o}, {31'b0, hz});
    chk("id_illegal", {31'b0, id_illegal_o}, {31'b0, v && !d.legal});
    last_hz    = hz;
    last_stall = st;
    if (!st) begin
      adv++;
      if (v && d.legal && !fl && !hz) begin
        m_ex.valid   = 1'b1;
        m_ex.memread = d.memread;
        m_ex.aluop   = d.aluop;
        m_ex.alusrc  = d.alusrc;
        m_ex.branch  = d.branch;
        m_ex.pcread  = d.pcread;
        m_ex.rd      = rd;
        e.memwrite   = d.memwrite;
        e.memread    = d.memread;
        e.memtoreg   = d.memtoreg;
        e.regwrite   = d.regwrite && (rd != 0);
        e.addpc      = d.addpc;
        e.rd         = rd;
        e.due        = adv + 2;
        exp_q.push_back(e);
      end else begin
        m_ex = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0; id_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("async_reset",
        {4'b0, ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_pcread_o, ex_rd_o,
         mem_valid_o, mem_memwrite_o, mem_memread_o, mem_rd_o,
         wb_valid_o, wb_memtoreg_o, wb_regwrite_o, wb_addpc_o, wb_rd_o}, 32'h0);
    exp_q.delete();
    m_ex = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: retire finished entries, then compare all three stages
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < adv) void'(exp_q.pop_front());
      exp_wb  = '0;
      exp_mem = '0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k].due == adv)
          exp_wb = {1'b1, exp_q[k].memtoreg, exp_q[k].regwrite, exp_q[k].addpc, exp_q[k].rd};
        if (exp_q[k].due == adv + 1)
          exp_mem = {1'b1, exp_q[k].memwrite, exp_q[k].memread, exp_q[k].rd};
      end
      chk("ex_bundle",
          {21'b0, ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_pcread_o, ex_rd_o},
          {21'b0, m_ex.valid, m_ex.aluop, m_ex.alusrc, m_ex.branch, m_ex.pcread, m_ex.rd});
      chk("mem_bundle", {24'b0, mem_valid_o, mem_memwrite_o, mem_memread_o, mem_rd_o},
          {24'b0, exp_mem});
      chk("wb_bundle", {23'b0, wb_valid_o, wb_memtoreg_o, wb_regwrite_o, wb_addpc_o, wb_rd_o},
          {23'b0, exp_wb});
    end
  end

  logic [6:0] ops [12] = '{OP_LW, OP_ADDI, OP_SW, OP_ADD, OP_BEQ, OP_JALR, OP_JAL,
                           OP_LUI, OP_AUIPC, 7'b0110000, 7'b0110010, 7'b1111111};

  initial begin
    bit         hold;
    bit         v;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;

    m_ex = '0; adv = 0; last_stall = 0; last_hz = 0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {4'b0, ex_valid_o, ex_aluop_o, ex_alusrc_o, ex_branch_o, ex_pcread_o, ex_rd_o,
         mem_valid_o, mem_memwrite_o, mem_memread_o, mem_rd_o,
         wb_valid_o, wb_memtoreg_o, wb_regwrite_o, wb_addpc_o, wb_rd_o}, 32'h0);
    #2 rst_n = 1'b1;

    // Full decode list, no stalls
    for (int k = 0; k < 9; k++) step(1'b1, ops[k], 5'(k + 1), 5'd31, 5'd30, 1'b0, 1'b0);
    idle(3);

    // Load-use on rs1, then x0 load (no stall), LUI (no rs use), SW rs2 hit
    step(1, OP_LW, 5, 1, 2, 0, 0);  step(1, OP_ADD, 6, 5, 7, 0, 0);  step(1, OP_ADD, 6, 5, 7, 0, 0);
    step(1, OP_LW, 0, 1, 2, 0, 0);  step(1, OP_ADD, 6, 0, 7, 0, 0);
    step(1, OP_LW, 5, 1, 2, 0, 0);  step(1, OP_LUI, 5, 5, 5, 0, 0);
    step(1, OP_LW, 5, 1, 2, 0, 0);  step(1, OP_SW, 0, 1, 5, 0, 0);   step(1, OP_SW, 0, 1, 5, 0, 0);
    idle(3);

    // Branch in EX flushed; flush held under stall waits for stall release
    step(1, OP_BEQ, 0, 1, 2, 0, 0); step(1, OP_ADDI, 9, 1, 0, 0, 1);
    step(1, OP_ADDI, 10, 1, 0, 1, 1); step(1, OP_ADDI, 10, 1, 0, 1, 1);
    step(1, OP_ADDI, 10, 1, 0, 0, 1); step(1, OP_ADDI, 11, 1, 0, 0, 0);

    // Four-cycle stall on a full pipe
    step(1, OP_ADDI, 12, 1, 0, 0, 0); step(1, OP_ADD, 13, 1, 2, 0, 0); step(1, OP_JAL, 14, 0, 0, 0, 0);
    repeat (4) step(1, OP_LW, 15, 1, 0, 1, 0);
    step(1, OP_LW, 15, 1, 0, 0, 0);

    // Illegal opcodes and ADDI to x0
    step(1, 7'b0110000, 3, 1, 2, 0, 0); step(1, 7'b0110010, 3, 1, 2, 0, 0);
    step(1, OP_ADDI, 0, 1, 0, 0, 0);
    idle(2);

    step(1, OP_LW, 4, 1, 2, 0, 0); step(1, OP_ADD, 5, 4, 4, 0, 0);
    reset_pulse();
    idle(2);

    // Randomised traffic with a front end that holds on stall/hazard
    hold = 0; v = 0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
    for (int i = 0; i < 400; i++) begin
      bit st, fl;
      if (!hold) begin
        v   = ($urandom_range(7) != 0);
        op  = ($urandom_range(15) == 0) ? 7'($urandom) : ops[$urandom_range(11)];
        rd  = 5'($urandom_range(7));
        rs1 = 5'($urandom_range(7));
        rs2 = 5'($urandom_range(7));
      end
      st = ($urandom_range(7) == 0);
      fl = ($urandom_range(9) == 0);
      step(v, op, rd, rs1, rs2, st, fl);
      hold = last_stall || (last_hz && !fl);
      if (i == 200) reset_pulse();
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
